// File: rtl/log_mem_port_arbiter.sv
// Shares the VR log data memory port between the log writer and the log reader.
// Bursts are atomic, ties are round-robin, and outstanding reads are bounded.
module log_mem_port_arbiter #(
  parameter int ADDR_W          = 12,
  parameter int DATA_W          = 512,
  parameter int MAX_RD_OUT      = 4,
  parameter int MAX_BURST_BEATS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_val,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              rd_val,
  input  logic              rd_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              rd_resp_val,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              rd_resp_rdy,
  output logic              mem_val,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic              mem_resp_val,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              mem_resp_rdy,
  output logic              burst_err
);

  localparam int CNT_W  = $clog2(MAX_RD_OUT + 1);
  localparam int BEAT_W = $clog2(MAX_BURST_BEATS + 1);
  localparam logic [CNT_W-1:0]  RD_OUT_MAX = CNT_W'(MAX_RD_OUT);
  localparam logic [BEAT_W-1:0] BEAT_MAX   = BEAT_W'(MAX_BURST_BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              last_grant_wr_r;
  logic [CNT_W-1:0]  rd_out_cnt_r;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic              burst_err_r;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              sel_wr_s;
  logic              sel_rd_s;
  logic              wr_hs_s;
  logic              rd_hs_s;
  logic              hs_last_s;
  logic              rd_inc_s;
  logic              rd_dec_s;

  assign wr_ok_s      = wr_val;
  assign rd_ok_s      = rd_val & (rd_out_cnt_r < RD_OUT_MAX);
  assign wr_hs_s      = wr_val & wr_rdy;
  assign rd_hs_s      = rd_val & rd_rdy;
  assign hs_last_s    = (wr_hs_s & wr_last) | (rd_hs_s & rd_last);
  assign rd_inc_s     = mem_val & mem_rdy & ~mem_we;
  assign rd_dec_s     = rd_resp_val & rd_resp_rdy;
  assign rd_resp_val  = mem_resp_val;
  assign rd_resp_data = mem_resp_data;
  assign burst_err    = burst_err_r;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: enter a burst on a non-last beat, leave on the last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_hs_s && !wr_last) begin
          state_nxt_s = WR_BURST;
        end else if (rd_hs_s && !rd_last) begin
          state_nxt_s = RD_BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_BURST: begin
        if (wr_hs_s && wr_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_BURST;
        end
      end
      RD_BURST: begin
        if (rd_hs_s && rd_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output selection: winner's beat goes straight to memory in the same cycle.
  always_comb begin
    sel_wr_s = 1'b0;
    sel_rd_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_ok_s && rd_ok_s) begin
          sel_wr_s = ~last_grant_wr_r;
          sel_rd_s = last_grant_wr_r;
        end else begin
          sel_wr_s = wr_ok_s;
          sel_rd_s = rd_ok_s;
        end
      end
      WR_BURST: sel_wr_s = 1'b1;
      RD_BURST: sel_rd_s = 1'b1;
      default: begin
        sel_wr_s = 1'b0;
        sel_rd_s = 1'b0;
      end
    endcase
    mem_val      = ~rst & ((sel_wr_s & wr_val) | (sel_rd_s & rd_ok_s));
    mem_we       = sel_wr_s;
    wr_rdy       = ~rst & sel_wr_s & mem_rdy;
    rd_rdy       = ~rst & sel_rd_s & rd_ok_s & mem_rdy;
    mem_resp_rdy = ~rst & rd_resp_rdy;
    if (sel_wr_s) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_addr  = rd_addr;
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Round-robin memory, outstanding-read count and burst length watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_wr_r <= 1'b0;
      rd_out_cnt_r    <= {CNT_W{1'b0}};
      beat_cnt_r      <= {BEAT_W{1'b0}};
      burst_err_r     <= 1'b0;
    end else begin
      if (wr_hs_s) begin
        last_grant_wr_r <= 1'b1;
      end else if (rd_hs_s) begin
        last_grant_wr_r <= 1'b0;
      end else begin
        last_grant_wr_r <= last_grant_wr_r;
      end

      if (rd_inc_s && !rd_dec_s && (rd_out_cnt_r < RD_OUT_MAX)) begin
        rd_out_cnt_r <= rd_out_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (rd_dec_s && !rd_inc_s && (rd_out_cnt_r != {CNT_W{1'b0}})) begin
        rd_out_cnt_r <= rd_out_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        rd_out_cnt_r <= rd_out_cnt_r;
      end

      if (hs_last_s) begin
        beat_cnt_r <= {BEAT_W{1'b0}};
      end else if ((wr_hs_s || rd_hs_s) && (beat_cnt_r < BEAT_MAX)) begin
        beat_cnt_r <= beat_cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end

      // The beat that brings the count to the limit without last is the violation.
      if ((wr_hs_s || rd_hs_s) && !hs_last_s && (beat_cnt_r >= BEAT_MAX - {{(BEAT_W-1){1'b0}}, 1'b1})) begin
        burst_err_r <= 1'b1;
      end else begin
        burst_err_r <= burst_err_r;
      end
    end
  end

endmodule

// File: tb/tb_log_mem_port_arbiter.sv
// Directed bench for log_mem_port_arbiter: a cycle table for arbitration plus
// hand sequences for read throttling, memory stalls, burst overrun and reset.
module tb_log_mem_port_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_val, wr_last, wr_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_val, rd_last, rd_rdy;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_val, rd_resp_rdy;
  logic [DATA_W-1:0] rd_resp_data;
  logic              mem_val, mem_we, mem_rdy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_val, mem_resp_rdy;
  logic [DATA_W-1:0] mem_resp_data;
  logic              burst_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  log_mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_val(wr_val), .wr_last(wr_last), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_val(rd_val), .rd_last(rd_last), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data), .rd_resp_rdy(rd_resp_rdy),
    .mem_val(mem_val), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .mem_resp_rdy(mem_resp_rdy), .burst_err(burst_err)
  );

  typedef struct {
    logic              wv, wl;
    logic [ADDR_W-1:0] wa;
    logic              rv, rl;
    logic [ADDR_W-1:0] ra;
    logic              mrdy, resp;
    logic              e_mv, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic              e_wrdy, e_rrdy;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int extra;
    int idx;

    // wv wl wa rv rl ra mrdy resp | mv we addr wrdy rrdy
    vecs[0]  = '{1'b1, 1'b0, 12'h020, 1'b1, 1'b0, 12'h030, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 12'h021, 1'b1, 1'b0, 12'h030, 1'b1, 1'b0, 1'b1, 1'b1, 12'h021, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h030, 1'b1, 1'b0, 1'b1, 1'b0, 12'h030, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h031, 1'b1, 1'b0, 1'b1, 1'b0, 12'h031, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h010, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 12'h011, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h011, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 12'h012, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h012, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h040, 1'b1, 1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 12'h050, 1'b1, 1'b0, 12'h041, 1'b1, 1'b0, 1'b1, 1'b0, 12'h041, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 12'h050, 1'b1, 1'b1, 12'h042, 1'b1, 1'b0, 1'b1, 1'b0, 12'h042, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 12'h050, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h050, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 12'h060, 1'b1, 1'b1, 12'h061, 1'b1, 1'b1, 1'b1, 1'b0, 12'h061, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 12'h060, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h060, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 12'h070, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 12'h070, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 12'h070, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h070, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

    rst = 1'b1;
    wr_val = 1'b1; wr_last = 1'b0; wr_addr = 12'h000; wr_data = {DATA_W{1'b0}};
    rd_val = 1'b1; rd_last = 1'b0; rd_addr = 12'h000; rd_resp_rdy = 1'b0;
    mem_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_data = {DATA_W{1'b0}};
    tick();
    tick();
    chk("rst_mem_val", mem_val, 1'b0);
    chk("rst_wr_rdy", wr_rdy, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_burst_err", burst_err, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      wr_val = vecs[i].wv; wr_last = vecs[i].wl; wr_addr = vecs[i].wa;
      wr_data = DATA_W'(vecs[i].wa);
      rd_val = vecs[i].rv; rd_last = vecs[i].rl; rd_addr = vecs[i].ra;
      mem_rdy = vecs[i].mrdy;
      mem_resp_val = vecs[i].resp; rd_resp_rdy = vecs[i].resp;
      #4;
      chk($sformatf("v%0d_mem_val", i), mem_val, vecs[i].e_mv);
      chk($sformatf("v%0d_wr_rdy", i), wr_rdy, vecs[i].e_wrdy);
      chk($sformatf("v%0d_rd_rdy", i), rd_rdy, vecs[i].e_rrdy);
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        if (vecs[i].e_we) begin
          chk($sformatf("v%0d_wdata", i), mem_wdata == DATA_W'(vecs[i].e_addr), 1'b1);
        end
      end
      tick();
    end

    // Read throttling with responses withheld.
    wr_val = 1'b0; wr_last = 1'b0; mem_resp_val = 1'b0; rd_resp_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      rd_val = 1'b1; rd_addr = 12'h100 + 12'(acc); rd_last = (acc == 5); mem_rdy = 1'b1;
      #4;
      if (rd_rdy) begin
        chk("t4_addr", mem_addr, 12'h100 + 12'(acc));
        chk("t4_we", mem_we, 1'b0);
        acc++;
      end
      tick();
    end
    chk("t4_accepted", acc, 4);
    chk("t4_blocked", mem_val, 1'b0);
    mem_resp_val = 1'b1; rd_resp_rdy = 1'b1; mem_resp_data = DATA_W'(32'hABCD1234);
    #4;
    chk("t4_resp_val", rd_resp_val, 1'b1);
    chk("t4_resp_data", rd_resp_data == DATA_W'(32'hABCD1234), 1'b1);
    chk("t4_mem_resp_rdy", mem_resp_rdy, 1'b1);
    tick();
    mem_resp_val = 1'b0; rd_resp_rdy = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      rd_addr = 12'h100 + 12'(acc); rd_last = (acc == 5);
      #4;
      if (rd_rdy) begin
        chk("t4_addr2", mem_addr, 12'h100 + 12'(acc));
        acc++;
        extra++;
      end
      tick();
    end
    chk("t4_one_more", extra, 1);
    mem_resp_val = 1'b1; rd_resp_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rd_val = (acc < 6); rd_addr = 12'h100 + 12'(acc); rd_last = (acc == 5);
      #4;
      if (rd_val && rd_rdy) acc++;
      tick();
    end
    chk("t4_done", acc, 6);
    rd_val = 1'b0; rd_last = 1'b0; mem_resp_val = 1'b0; rd_resp_rdy = 1'b0;

    // Write burst under a toggling memory ready.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      wr_val = (idx < 4); wr_addr = 12'h200 + 12'(idx); wr_last = (idx == 3);
      wr_data = DATA_W'(12'h200 + 12'(idx));
      mem_rdy = (c % 2 == 1);
      #4;
      if (idx < 4) begin
        chk("t5_addr", mem_addr, 12'h200 + 12'(idx));
        chk("t5_wr_rdy", wr_rdy, mem_rdy);
        chk("t5_mem_val", mem_val, 1'b1);
        if (wr_rdy) idx++;
      end
      tick();
    end
    chk("t5_beats", idx, 4);

    // 65 beats with no last, then reset clears the sticky error.
    mem_rdy = 1'b1; wr_last = 1'b0;
    for (int i = 0; i < 65; i++) begin
      wr_val = 1'b1; wr_addr = 12'(i);
      tick();
      if (i == 62) chk("t6_err_63", burst_err, 1'b0);
      if (i == 63) chk("t6_err_64", burst_err, 1'b1);
      if (i == 64) chk("t6_err_65", burst_err, 1'b1);
    end
    rst = 1'b1; rd_val = 1'b1;
    #1;
    chk("t6_rst_err", burst_err, 1'b0);
    chk("t6_rst_wr_rdy", wr_rdy, 1'b0);
    chk("t6_rst_rd_rdy", rd_rdy, 1'b0);
    chk("t6_rst_mem_val", mem_val, 1'b0);
    tick();
    rst = 1'b0; rd_val = 1'b0; wr_val = 1'b1; wr_last = 1'b1; wr_addr = 12'h300;
    #4;
    chk("t6_post_we", mem_we, 1'b1);
    chk("t6_post_rdy", wr_rdy, 1'b1);
    chk("t6_post_addr", mem_addr, 12'h300);
    tick();
    chk("t6_post_err", burst_err, 1'b0);
    wr_val = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
